// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_ctrl_pkg
//  Description : Shared definitions for the pipeline control slice of the
//                16-bit core: sequencer state encoding and the default
//                widths of the register specifier and event counters.
//  Revision    : 1.0  initial release
// ============================================================================
package cpu_ctrl_pkg;

    // Default register-specifier width (8 architectural registers).
    localparam int c_reg_addr_w = 3;

    // Default width of the debug event counters.
    localparam int c_cnt_w = 16;

    // Pipeline sequencer states.
    typedef enum logic [1:0] {
        ST_RUN          = 2'd0,
        ST_BRANCH_FLUSH = 2'd1,
        ST_MEM_WAIT     = 2'd2,
        ST_HALTED       = 2'd3
    } state_t;

endpackage : cpu_ctrl_pkg
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Up-counter that increments by one on each enabled cycle and
//                holds at all-ones instead of wrapping.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk    in   1      counting clock, rising edge
//    rst_n  in   1      asynchronous active-low clear
//    inc    in   1      increment request for this cycle
//    count  out  WIDTH  current count value
// ============================================================================
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] c_max = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_one = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (inc && (r_count != c_max)) begin
            r_count <= r_count + c_one;
        end
    end

    assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/pipeline_controller.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_controller
//  Description : Central sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB
//                stage buffers and the PC. Resolves hazard sources into
//                per-buffer write enables, registered active-low flushes and
//                the ID/EX bubble select, and keeps saturating stall/flush
//                event counters for the debug port.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk               in   1           core clock, rising edge
//    reset             in   1           asynchronous active-low reset
//    memBusy           in   1           data memory access still pending
//    branchTaken       in   1           EX resolved a taken branch/jump
//    idexMemRead       in   1           ID/EX instruction is a load
//    idexRd            in   REG_ADDR_W  ID/EX destination register
//    ifidRs            in   REG_ADDR_W  IF/ID source 1
//    ifidRt            in   REG_ADDR_W  IF/ID source 2
//    ifidUsesRt        in   1           IF/ID instruction reads ifidRt
//    haltRetired       in   1           HALT is in MEM/WB
//    pcWriteEnable     out  1           PC load enable
//    *WriteEnable      out  1 each      stage buffer write enables
//    *Flush_n          out  1 each      registered active-low buffer clears
//    idexBubble        out  1           zero control fields at ID/EX input
//    halted            out  1           core stopped (sticky until reset)
//    stallCount        out  CNT_W       saturating stalled-cycle count
//    flushCount        out  CNT_W       saturating branch-flush count
// ============================================================================
module pipeline_controller
    import cpu_ctrl_pkg::*;
#(
    parameter int REG_ADDR_W = c_reg_addr_w,
    parameter int CNT_W      = c_cnt_w
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  memBusy,
    input  logic                  branchTaken,
    input  logic                  idexMemRead,
    input  logic [REG_ADDR_W-1:0] idexRd,
    input  logic [REG_ADDR_W-1:0] ifidRs,
    input  logic [REG_ADDR_W-1:0] ifidRt,
    input  logic                  ifidUsesRt,
    input  logic                  haltRetired,
    output logic                  pcWriteEnable,
    output logic                  ifidWriteEnable,
    output logic                  idexWriteEnable,
    output logic                  exmemWriteEnable,
    output logic                  memwbWriteEnable,
    output logic                  ifidFlush_n,
    output logic                  idexFlush_n,
    output logic                  exmemFlush_n,
    output logic                  memwbFlush_n,
    output logic                  idexBubble,
    output logic                  halted,
    output logic [CNT_W-1:0]      stallCount,
    output logic [CNT_W-1:0]      flushCount
);

    state_t r_state;
    state_t w_next_state;

    logic r_ifid_flush_n;
    logic r_idex_flush_n;
    logic r_exmem_flush_n;
    logic r_memwb_flush_n;
    logic r_halted;

    logic w_load_use;
    logic w_in_flush;
    logic w_pc_we;
    logic w_ifid_we;
    logic w_idex_we;
    logic w_exmem_we;
    logic w_memwb_we;
    logic w_bubble;
    logic w_take_branch;
    logic w_stall_inc;

    // Load in ID/EX writes a register that the IF/ID instruction reads.
    // Register 0 is hard-wired, so a load to it never creates a hazard.
    assign w_load_use = idexMemRead && (idexRd != '0) &&
                        ((idexRd == ifidRs) || (ifidUsesRt && (idexRd == ifidRt)));

    // In BRANCH_FLUSH the IF/ID and ID/EX slots hold wrong-path instructions,
    // so branch and load-use indications from them are not trusted.
    assign w_in_flush = (r_state == ST_BRANCH_FLUSH);

    // Hazard resolution. RUN and MEM_WAIT share the same priority list:
    // a MEM_WAIT cycle with memBusy still high lands on the memBusy branch
    // and simply stays in MEM_WAIT.
    always_comb begin
        w_pc_we       = 1'b1;
        w_ifid_we     = 1'b1;
        w_idex_we     = 1'b1;
        w_exmem_we    = 1'b1;
        w_memwb_we    = 1'b1;
        w_bubble      = 1'b0;
        w_take_branch = 1'b0;
        w_next_state  = ST_RUN;

        if (r_state == ST_HALTED) begin
            w_pc_we      = 1'b0;
            w_ifid_we    = 1'b0;
            w_idex_we    = 1'b0;
            w_exmem_we   = 1'b0;
            w_memwb_we   = 1'b0;
            w_next_state = ST_HALTED;
        end else if (haltRetired) begin
            w_pc_we      = 1'b0;
            w_ifid_we    = 1'b0;
            w_idex_we    = 1'b0;
            w_exmem_we   = 1'b0;
            w_memwb_we   = 1'b0;
            w_next_state = ST_HALTED;
        end else if (memBusy) begin
            w_pc_we      = 1'b0;
            w_ifid_we    = 1'b0;
            w_idex_we    = 1'b0;
            w_exmem_we   = 1'b0;
            w_memwb_we   = 1'b0;
            w_next_state = ST_MEM_WAIT;
        end else if (branchTaken && !w_in_flush) begin
            // Let the branch target load; the wrong-path slots are cleared
            // by the registered flushes during the following cycle.
            w_take_branch = 1'b1;
            w_next_state  = ST_BRANCH_FLUSH;
        end else if (w_load_use && !w_in_flush) begin
            // Hold PC and IF/ID for one cycle, push a bubble into ID/EX.
            w_pc_we   = 1'b0;
            w_ifid_we = 1'b0;
            w_bubble  = 1'b1;
        end
    end

    // Sequencer state and registered (glitch-free) flush/halt outputs.
    // Reset pulls every flush low so all buffers stay clear while reset is
    // asserted. The front-end flushes go low for exactly the cycle after a
    // taken branch; the back-end flushes only ever follow reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state         <= ST_RUN;
            r_ifid_flush_n  <= 1'b0;
            r_idex_flush_n  <= 1'b0;
            r_exmem_flush_n <= 1'b0;
            r_memwb_flush_n <= 1'b0;
            r_halted        <= 1'b0;
        end else begin
            r_state         <= w_next_state;
            r_ifid_flush_n  <= !w_take_branch;
            r_idex_flush_n  <= !w_take_branch;
            r_exmem_flush_n <= 1'b1;
            r_memwb_flush_n <= 1'b1;
            r_halted        <= (w_next_state == ST_HALTED);
        end
    end

    // A frozen PC outside HALTED is a stalled cycle.
    assign w_stall_inc = !w_pc_we && (r_state != ST_HALTED);

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (w_stall_inc),
        .count (stallCount)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .rst_n (reset),
        .inc   (w_take_branch),
        .count (flushCount)
    );

    assign pcWriteEnable    = w_pc_we;
    assign ifidWriteEnable  = w_ifid_we;
    assign idexWriteEnable  = w_idex_we;
    assign exmemWriteEnable = w_exmem_we;
    assign memwbWriteEnable = w_memwb_we;
    assign idexBubble       = w_bubble;
    assign ifidFlush_n      = r_ifid_flush_n;
    assign idexFlush_n      = r_idex_flush_n;
    assign exmemFlush_n     = r_exmem_flush_n;
    assign memwbFlush_n     = r_memwb_flush_n;
    assign halted           = r_halted;

endmodule : pipeline_controller
`default_nettype wire

// File: tb/tb_pipeline_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_controller
//  Description : Directed self-checking bench for pipeline_controller.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipeline_controller;

    logic        clk;
    logic        reset;
    logic        memBusy;
    logic        branchTaken;
    logic        idexMemRead;
    logic [2:0]  idexRd;
    logic [2:0]  ifidRs;
    logic [2:0]  ifidRt;
    logic        ifidUsesRt;
    logic        haltRetired;
    logic        pcWriteEnable;
    logic        ifidWriteEnable;
    logic        idexWriteEnable;
    logic        exmemWriteEnable;
    logic        memwbWriteEnable;
    logic        ifidFlush_n;
    logic        idexFlush_n;
    logic        exmemFlush_n;
    logic        memwbFlush_n;
    logic        idexBubble;
    logic        halted;
    logic [15:0] stallCount;
    logic [15:0] flushCount;

    int n_checks = 0;
    int n_pass   = 0;

    pipeline_controller u_dut (
        .clk              (clk),
        .reset            (reset),
        .memBusy          (memBusy),
        .branchTaken      (branchTaken),
        .idexMemRead      (idexMemRead),
        .idexRd           (idexRd),
        .ifidRs           (ifidRs),
        .ifidRt           (ifidRt),
        .ifidUsesRt       (ifidUsesRt),
        .haltRetired      (haltRetired),
        .pcWriteEnable    (pcWriteEnable),
        .ifidWriteEnable  (ifidWriteEnable),
        .idexWriteEnable  (idexWriteEnable),
        .exmemWriteEnable (exmemWriteEnable),
        .memwbWriteEnable (memwbWriteEnable),
        .ifidFlush_n      (ifidFlush_n),
        .idexFlush_n      (idexFlush_n),
        .exmemFlush_n     (exmemFlush_n),
        .memwbFlush_n     (memwbFlush_n),
        .idexBubble       (idexBubble),
        .halted           (halted),
        .stallCount       (stallCount),
        .flushCount       (flushCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pc, ifid, idex, exmem, memwb}
    logic [4:0] w_we;
    // {ifid, idex, exmem, memwb}
    logic [3:0] w_fl;
    assign w_we = {pcWriteEnable, ifidWriteEnable, idexWriteEnable,
                   exmemWriteEnable, memwbWriteEnable};
    assign w_fl = {ifidFlush_n, idexFlush_n, exmemFlush_n, memwbFlush_n};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; returns at the falling edge where inputs are driven.
    task automatic next_cycle;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs;
        memBusy     = 1'b0;
        branchTaken = 1'b0;
        idexMemRead = 1'b0;
        idexRd      = 3'd0;
        ifidRs      = 3'd0;
        ifidRt      = 3'd0;
        ifidUsesRt  = 1'b0;
        haltRetired = 1'b0;
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        reset = 1'b1;
        #1 reset = 1'b0;

        // ---- reset held 3 cycles ----
        repeat (3) next_cycle();
        #1;
        check("rst_flush",  w_fl,       4'b0000);
        check("rst_halted", halted,     1'b0);
        check("rst_stall",  stallCount, 16'd0);
        check("rst_flushc", flushCount, 16'd0);
        reset = 1'b1;
        #1 check("rel_flush_pre_edge", w_fl, 4'b0000);
        next_cycle();
        #1;
        check("rel_flush", w_fl,       4'b1111);
        check("rel_we",    w_we,       5'b11111);
        check("rel_bub",   idexBubble, 1'b0);
        check("rel_stall", stallCount, 16'd0);

        // ---- load-use on rs ----
        idexMemRead = 1'b1; idexRd = 3'd3; ifidRs = 3'd3;
        #1;
        check("lu_rs_we",  w_we,       5'b00111);
        check("lu_rs_bub", idexBubble, 1'b1);
        next_cycle();
        idle_inputs();
        #1;
        check("lu_rs_stall", stallCount, 16'd1);
        check("lu_rs_after", w_we,       5'b11111);

        // ---- load to r0 never hazards ----
        idexMemRead = 1'b1; idexRd = 3'd0; ifidRs = 3'd0;
        #1 check("lu_r0_we", w_we, 5'b11111);
        next_cycle();

        // ---- rt match but rt unused ----
        idexMemRead = 1'b1; idexRd = 3'd5; ifidRs = 3'd1; ifidRt = 3'd5; ifidUsesRt = 1'b0;
        #1 check("lu_rt_unused_we", w_we, 5'b11111);
        next_cycle();

        // ---- rt match and rt used ----
        ifidUsesRt = 1'b1;
        #1;
        check("lu_rt_we",  w_we,       5'b00111);
        check("lu_rt_bub", idexBubble, 1'b1);
        next_cycle();
        idle_inputs();
        #1 check("lu_rt_stall", stallCount, 16'd2);

        // ---- taken branch ----
        branchTaken = 1'b1;
        #1 check("br_we", w_we, 5'b11111);
        next_cycle();
        // In BRANCH_FLUSH: branch and load-use are ignored.
        branchTaken = 1'b1; idexMemRead = 1'b1; idexRd = 3'd2; ifidRs = 3'd2;
        #1;
        check("br_flush",      w_fl,       4'b0011);
        check("br_flushc",     flushCount, 16'd1);
        check("br_ignore_we",  w_we,       5'b11111);
        check("br_ignore_bub", idexBubble, 1'b0);
        next_cycle();
        idle_inputs();
        #1;
        check("br_flush_end", w_fl,       4'b1111);
        check("br_flushc2",   flushCount, 16'd1);
        check("br_stall",     stallCount, 16'd2);

        // ---- memBusy for 4 cycles with branch pending ----
        for (int i = 0; i < 4; i++) begin
            memBusy = 1'b1; branchTaken = 1'b1;
            #1;
            check($sformatf("mb_we_%0d", i),    w_we, 5'b00000);
            check($sformatf("mb_flush_%0d", i), w_fl, 4'b1111);
            next_cycle();
        end
        memBusy = 1'b0; branchTaken = 1'b1;
        #1;
        check("mb_rel_we",    w_we,       5'b11111);
        check("mb_stall",     stallCount, 16'd6);
        check("mb_flushc_pre", flushCount, 16'd1);
        next_cycle();
        idle_inputs();
        #1;
        check("mb_br_flush",  w_fl,       4'b0011);
        check("mb_br_flushc", flushCount, 16'd2);
        next_cycle();
        #1 check("mb_br_flush_end", w_fl, 4'b1111);

        // ---- halt ----
        haltRetired = 1'b1;
        #1 check("halt_we0", w_we, 5'b00000);
        next_cycle();
        haltRetired = 1'b0;
        #1;
        check("halt_halted", halted,     1'b1);
        check("halt_we",     w_we,       5'b00000);
        check("halt_stall",  stallCount, 16'd7);
        repeat (3) next_cycle();
        #1;
        check("halt_sticky",       halted,     1'b1);
        check("halt_sticky_we",    w_we,       5'b00000);
        check("halt_no_count",     stallCount, 16'd7);
        check("halt_flush",        w_fl,       4'b1111);
        reset = 1'b0;
        #1;
        check("halt_rst_halted", halted,     1'b0);
        check("halt_rst_flush",  w_fl,       4'b0000);
        check("halt_rst_stall",  stallCount, 16'd0);
        check("halt_rst_flushc", flushCount, 16'd0);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        #1;
        check("post_rst_we",     w_we,   5'b11111);
        check("post_rst_halted", halted, 1'b0);
        check("post_rst_flush",  w_fl,   4'b1111);

        // ---- stall counter saturation ----
        memBusy = 1'b1;
        repeat (65534) next_cycle();
        #1 check("sat_fffe", stallCount, 16'hFFFE);
        next_cycle();
        #1 check("sat_ffff", stallCount, 16'hFFFF);
        repeat (3) next_cycle();
        #1;
        check("sat_hold",   stallCount, 16'hFFFF);
        check("sat_flushc", flushCount, 16'd0);
        idle_inputs();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_pipeline_controller
`default_nettype wire
